cmd_interp_fsm: RTL and testbench
=================================

CMD_INTERP_FSM -- requirements
Module: cmd_interp_fsm

Interface
REQ-001 The block SHALL have parameter TMO, default 255, giving the maximum number of WAIT cycles before timeout (range 1..255).
REQ-002 The block SHALL have port clk, input, 1 bit: system clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-004 The block SHALL have port got_dig, input, 1 bit: one-cycle pulse, registered byte is an ASCII digit.
REQ-005 The block SHALL have port got_op, input, 1 bit: one-cycle pulse, registered byte is an operator: * + - /.
REQ-006 The block SHALL have port got_eq, input, 1 bit: one-cycle pulse, byte is '=' or CR.
REQ-007 The block SHALL have port got_esc, input, 1 bit: one-cycle pulse, byte is ESC.
REQ-008 The block SHALL have port data, input, 8 bits: ASCII byte aligned with the got_* pulses.
REQ-009 The block SHALL have port calc_done, input, 1 bit: ALU completion pulse.
REQ-010 The block SHALL have port op_a, output, 14 bits: first operand, binary.
REQ-011 The block SHALL have port op_b, output, 14 bits: second operand, binary.
REQ-012 The block SHALL have port op_code, output, 2 bits: operator code, + = 00, - = 01, * = 10, / = 11.
REQ-013 The block SHALL have port calc_start, output, 1 bit: one-cycle ALU launch pulse.
REQ-014 The block SHALL have port busy, output, 1 bit: high in CALC and WAIT.
REQ-015 The block SHALL have port err, output, 1 bit: high in ERR.
REQ-016 The block SHALL have port state, output, 3 bits: current FSM state code.

Function
REQ-017 States and codes SHALL be IDLE = 0, GET_A = 1, OP = 2, GET_B = 3, CALC = 4, WAIT = 5, ERR = 6; code 7 SHALL recover to IDLE on the next clock.
REQ-018 Each clock, the block SHALL act on at most one event, with priority got_esc > got_eq > got_op > got_dig when pulses coincide.
REQ-019 The digit value SHALL be data[3:0]; each digit append SHALL compute operand = operand*10 + digit, in 14-bit arithmetic.
REQ-020 Each operand SHALL take at most 4 digits (per-operand 3-bit digit counter); a 5th and later digit SHALL be ignored, with the operand unchanged.
REQ-021 In IDLE: got_dig SHALL load op_a = digit, set the A-count to 1 and go to GET_A; got_op and got_eq SHALL be ignored.
REQ-022 In GET_A: got_dig SHALL append to op_a; got_op SHALL latch op_code, clear op_b and its count, and go to OP; got_eq SHALL be ignored.
REQ-023 In OP: got_op SHALL overwrite op_code; got_dig SHALL load op_b = digit, set the B-count to 1 and go to GET_B; got_eq SHALL be ignored.
REQ-024 In GET_B: got_dig SHALL append to op_b and got_op SHALL be ignored.
REQ-025 In GET_B, got_eq SHALL go to ERR when op_code = 11 and op_b = 0, and to CALC otherwise.
REQ-026 In CALC: calc_start SHALL be 1 for exactly this one cycle, and the next state SHALL be WAIT, unconditionally.
REQ-027 In WAIT: all got_* inputs, including got_esc, SHALL be ignored; calc_done SHALL go to IDLE.
REQ-028 In WAIT: an 8-bit counter, cleared on WAIT entry, SHALL go to ERR when it reaches TMO without calc_done.
REQ-029 In WAIT: if calc_done arrives in the same cycle the counter reaches TMO, the block SHALL go to IDLE.
REQ-030 In ERR: only got_esc SHALL be acted on.
REQ-031 got_esc in IDLE, GET_A, OP, GET_B or ERR SHALL clear op_a, op_b, op_code and both digit counts, and go to IDLE next clock.
REQ-032 op_a, op_b and op_code SHALL hold stable from CALC entry until the next IDLE exit or got_esc.
REQ-033 Returning to IDLE via calc_done SHALL leave the operands unchanged.
REQ-034 All outputs SHALL be registered or decoded from registered state; busy = state is CALC or WAIT; err = state is ERR.

Reset
REQ-035 On rst = 0, the block SHALL immediately force state = IDLE, op_a = 0, op_b = 0, op_code = 00, calc_start = 0, busy = 0, err = 0, and clear both counters, regardless of current state.
REQ-036 Reset asserted during WAIT SHALL drop busy asynchronously, and no calc_start SHALL follow release.
REQ-037 The first clock edge after rst rises SHALL be a normal IDLE cycle.

Verification
REQ-038 Bench scenario: "12+34=" pulses, calc_done 3 cycles after calc_start -> op_a = 12, op_b = 34, op_code = 00, one calc_start pulse, busy for 4 cycles, then IDLE.
REQ-039 Bench scenario: "7/0=" -> state goes to ERR, err = 1, no calc_start; then ESC -> IDLE, all operands 0.
REQ-040 Bench scenario: "123456-" -> op_a = 1234, op_code = 01, state OP; then "+" -> op_code = 00.
REQ-041 Bench scenario: got_esc and got_dig asserted in the same cycle in GET_A -> IDLE, op_a = 0.
REQ-042 Bench scenario: "5*6=" with no calc_done and TMO = 10 -> ERR exactly 10 cycles after WAIT entry; ESC during WAIT ignored.
REQ-043 Bench scenario: rst pulsed low mid-WAIT -> busy = 0 without a clock edge; after release, the next digit starts GET_A normally.

Source files
------------

// File: rtl/cmd_interp_if.sv
// cmd_interp_if: token pulses in, operands and ALU handshake out of the command interpreter.
interface cmd_interp_if;
   logic        got_dig;
   logic        got_op;
   logic        got_eq;
   logic        got_esc;
   logic [7:0]  data;
   logic        calc_done;
   logic [13:0] op_a;
   logic [13:0] op_b;
   logic [1:0]  op_code;
   logic        calc_start;
   logic        busy;
   logic        err;
   logic [2:0]  state;
   modport master (
      output got_dig, got_op, got_eq, got_esc, data, calc_done,
      input  op_a, op_b, op_code, calc_start, busy, err, state
   );
   modport slave (
      input  got_dig, got_op, got_eq, got_esc, data, calc_done,
      output op_a, op_b, op_code, calc_start, busy, err, state
   );
endinterface

// File: rtl/cmd_interp_fsm.sv
// cmd_interp_fsm: turns "<digits><op><digits>=" keystrokes into two binary operands and an ALU launch.
module cmd_interp_fsm #(
   parameter int TMO = 255
) (
   input logic         clk,
   input logic         rst,
   cmd_interp_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      GET_A = 3'd1,
      OP    = 3'd2,
      GET_B = 3'd3,
      CALC  = 3'd4,
      WAIT  = 3'd5,
      ERR   = 3'd6
   } state_t;
   state_t      st, st_nx;
   logic [13:0] a, a_nx, b, b_nx, dig;
   logic [1:0]  oc, oc_nx, oc_dec;
   logic [2:0]  ca, ca_nx, cb, cb_nx;
   logic [7:0]  tc, tc_nx;
   logic        esc;
   assign dig    = {10'd0, bus.data[3:0]};
   assign oc_dec = bus.data == 8'h2D ? 2'b01 : bus.data == 8'h2A ? 2'b10 : bus.data == 8'h2F ? 2'b11 : 2'b00;
   // ESC is deliberately deaf while the ALU owns the operands
   assign esc    = bus.got_esc && st != CALC && st != WAIT;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         st <= IDLE;
         a  <= '0;
         b  <= '0;
         oc <= '0;
         ca <= '0;
         cb <= '0;
         tc <= '0;
      end else begin
         st <= st_nx;
         a  <= a_nx;
         b  <= b_nx;
         oc <= oc_nx;
         ca <= ca_nx;
         cb <= cb_nx;
         tc <= tc_nx;
      end
   always_comb begin
      st_nx = st;
      a_nx  = a;
      b_nx  = b;
      oc_nx = oc;
      ca_nx = ca;
      cb_nx = cb;
      tc_nx = tc;
      if (esc) begin
         st_nx = IDLE;
         a_nx  = '0;
         b_nx  = '0;
         oc_nx = '0;
         ca_nx = '0;
         cb_nx = '0;
      end else
         case (st)
            IDLE:
               if (!bus.got_eq && !bus.got_op && bus.got_dig) begin
                  a_nx  = dig;
                  ca_nx = 3'd1;
                  st_nx = GET_A;
               end
            GET_A:
               if (!bus.got_eq) begin
                  if (bus.got_op) begin
                     oc_nx = oc_dec;
                     b_nx  = '0;
                     cb_nx = '0;
                     st_nx = OP;
                  end else if (bus.got_dig && ca < 3'd4) begin
                     a_nx  = a * 14'd10 + dig;
                     ca_nx = ca + 3'd1;
                  end
               end
            OP:
               if (!bus.got_eq) begin
                  if (bus.got_op) oc_nx = oc_dec;
                  else if (bus.got_dig) begin
                     b_nx  = dig;
                     cb_nx = 3'd1;
                     st_nx = GET_B;
                  end
               end
            GET_B:
               if (bus.got_eq) st_nx = (oc == 2'b11 && b == '0) ? ERR : CALC;
               else if (!bus.got_op && bus.got_dig && cb < 3'd4) begin
                  b_nx  = b * 14'd10 + dig;
                  cb_nx = cb + 3'd1;
               end
            CALC: begin
               st_nx = WAIT;
               tc_nx = '0;
            end
            // calc_done wins over a timeout landing in the same cycle
            WAIT:
               if (bus.calc_done) st_nx = IDLE;
               else if (tc == 8'(TMO - 1)) st_nx = ERR;
               else tc_nx = tc + 8'd1;
            ERR:     st_nx = ERR;
            default: st_nx = IDLE;
         endcase
   end
   assign bus.op_a       = a;
   assign bus.op_b       = b;
   assign bus.op_code    = oc;
   assign bus.calc_start = st == CALC;
   assign bus.busy       = st == CALC || st == WAIT;
   assign bus.err        = st == ERR;
   assign bus.state      = st;
endmodule

// File: tb/tb_cmd_interp_fsm.sv
// tb_cmd_interp_fsm: keystroke-level reference model feeding a scoreboard of calc_start / err events.
module tb_cmd_interp_fsm;
   localparam int TMO_T = 10;
   logic clk = 1'b0;
   logic rst = 1'b0;
   cmd_interp_if bus ();
   cmd_interp_fsm #(.TMO(TMO_T)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;

   typedef struct {bit is_err; int a; int b; int c;} ev_t;
   ev_t sb[$];
   int  vecs = 0;
   int  miss = 0;
   // the typed line so far: digits of each operand, whether an operator was seen
   int  m_a[$];
   int  m_b[$];
   bit  m_op = 0;
   bit  m_err = 0;
   int  ra = 0, rb = 0, rc = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      vecs++;
      if (act !== exp) begin
         miss++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   function automatic int val(input int q[$]);
      int v = 0;
      foreach (q[i]) v = (v * 10 + q[i]) % 16384;
      return v;
   endfunction

   function automatic int opmap(input byte ch);
      return ch == "-" ? 1 : ch == "*" ? 2 : ch == "/" ? 3 : 0;
   endfunction

   function automatic int exp_state();
      return m_err ? 6 : m_a.size() == 0 ? 0 : !m_op ? 1 : m_b.size() == 0 ? 2 : 3;
   endfunction

   task automatic clear_all();
      m_a.delete();
      m_b.delete();
      m_op = 0;
      m_err = 0;
      ra = 0;
      rb = 0;
      rc = 0;
   endtask

   task automatic push_ev(input bit e);
      ev_t x;
      x.is_err = e;
      x.a = ra;
      x.b = rb;
      x.c = rc;
      sb.push_back(x);
   endtask

   task automatic drive(input bit esc, input bit eq, input bit op, input bit dig, input byte ch, input bit done);
      bus.got_esc = esc;
      bus.got_eq = eq;
      bus.got_op = op;
      bus.got_dig = dig;
      bus.data = ch;
      bus.calc_done = done;
      @(posedge clk);
      #1;
      bus.got_esc = 0;
      bus.got_eq = 0;
      bus.got_op = 0;
      bus.got_dig = 0;
      bus.calc_done = 0;
   endtask

   task automatic run_wait(input int d, input bit esc_noise, input int rst_at);
      @(negedge clk);
      chk("calc state", bus.state, 4);
      chk("calc busy", bus.busy, 1);
      drive(esc_noise, 0, 0, 1, "9", 0);
      for (int w = 0; w < TMO_T; w++) begin
         @(negedge clk);
         chk("wait state", bus.state, 5);
         chk("wait busy", bus.busy, 1);
         chk("wait calc_start", bus.calc_start, 0);
         if (w == rst_at) begin
            #2 rst = 0;
            #1;
            chk("rst busy", bus.busy, 0);
            chk("rst state", bus.state, 0);
            chk("rst op_a", bus.op_a, 0);
            chk("rst op_b", bus.op_b, 0);
            chk("rst op_code", bus.op_code, 0);
            chk("rst err", bus.err, 0);
            clear_all();
            @(negedge clk);
            @(negedge clk);
            rst = 1;
            return;
         end
         if (w == d) begin
            m_a.delete();
            m_b.delete();
            m_op = 0;
            drive(esc_noise, 0, 0, 0, 8'h1b, 1);
            return;
         end
         if (w == TMO_T - 1) begin
            m_err = 1;
            push_ev(1);
         end
         drive(esc_noise, 1'($urandom_range(0, 1)), 0, 0, "=", 0);
      end
   endtask

   task automatic tok(input bit esc, input bit eq, input bit op, input bit dig, input byte ch,
                      input int d = 3, input bit esc_noise = 0, input int rst_at = -1);
      bit go = 0;
      @(negedge clk);
      chk("state", bus.state, exp_state());
      chk("op_a", bus.op_a, ra);
      chk("op_b", bus.op_b, rb);
      chk("op_code", bus.op_code, rc);
      chk("busy", bus.busy, 0);
      chk("err", bus.err, m_err);
      if (m_err) begin
         if (esc) clear_all();
      end else if (esc) clear_all();
      else if (eq) begin
         if (m_b.size() > 0) begin
            if (rc == 3 && rb == 0) begin
               m_err = 1;
               push_ev(1);
            end else begin
               push_ev(0);
               go = 1;
            end
         end
      end else if (op) begin
         if (m_a.size() > 0 && m_b.size() == 0) begin
            if (!m_op) rb = 0;
            m_op = 1;
            rc = opmap(ch);
         end
      end else if (dig) begin
         if (!m_op) begin
            if (m_a.size() < 4) begin
               m_a.push_back(ch - "0");
               ra = val(m_a);
            end
         end else if (m_b.size() < 4) begin
            m_b.push_back(ch - "0");
            rb = val(m_b);
         end
      end
      drive(esc, eq, op, dig, ch, 0);
      if (go) run_wait(d, esc_noise, rst_at);
   endtask

   task automatic send(input string s, input int d = 3, input bit esc_noise = 0, input int rst_at = -1);
      for (int i = 0; i < s.len(); i++) begin
         byte c = s[i];
         if (c >= "0" && c <= "9") tok(0, 0, 0, 1, c);
         else if (c == "=") tok(0, 1, 0, 0, c, d, esc_noise, rst_at);
         else tok(0, 0, 1, 0, c);
      end
   endtask

   task automatic take(input bit e);
      ev_t x;
      if (sb.size() == 0) begin
         vecs++;
         miss++;
         $display("FAIL unexpected %s event: got one, expected none", e ? "err" : "calc_start");
      end else begin
         x = sb.pop_front();
         chk("event kind (1=err)", e, x.is_err);
         chk("event op_a", bus.op_a, x.a);
         chk("event op_b", bus.op_b, x.b);
         chk("event op_code", bus.op_code, x.c);
      end
   endtask

   initial begin
      bit ep = 0;
      forever begin
         @(posedge clk);
         #1;
         if (bus.calc_start === 1'b1) take(0);
         if (bus.err === 1'b1 && !ep) take(1);
         ep = bus.err === 1'b1;
      end
   end

   initial begin
      string ops = "+-*/";
      bus.got_esc = 0;
      bus.got_eq = 0;
      bus.got_op = 0;
      bus.got_dig = 0;
      bus.data = 0;
      bus.calc_done = 0;
      #3;
      chk("reset state", bus.state, 0);
      chk("reset busy", bus.busy, 0);
      chk("reset err", bus.err, 0);
      chk("reset calc_start", bus.calc_start, 0);
      chk("reset op_a", bus.op_a, 0);
      chk("reset op_code", bus.op_code, 0);
      @(negedge clk);
      rst = 1;
      send("12+34=", 2);
      tok(0, 0, 0, 0, 8'h00);
      send("7/0=");
      tok(0, 0, 0, 0, 8'h00);
      tok(1, 0, 0, 0, 8'h1b);
      tok(0, 0, 0, 0, 8'h00);
      send("123456-");
      tok(0, 0, 0, 0, 8'h00);
      send("+");
      tok(0, 0, 0, 0, 8'h00);
      send("4");
      tok(1, 0, 0, 1, "5");
      tok(0, 0, 0, 0, 8'h00);
      send("5*6=", 99, 1);
      tok(0, 0, 0, 0, 8'h00);
      tok(1, 0, 0, 0, 8'h1b);
      send("8-3=", 99, 0, 4);
      send("9");
      tok(0, 0, 0, 0, 8'h00);
      tok(1, 0, 0, 0, 8'h1b);
      repeat (400) begin
         int  r = $urandom_range(0, 99);
         byte c = 8'h00;
         bit  esc = 0, eq = 0, op = 0, dig = 0;
         if (r < 50) begin
            dig = 1;
            c = byte'(8'h30 + $urandom_range(0, 9));
         end else if (r < 70) begin
            op = 1;
            c = ops[$urandom_range(0, 3)];
         end else if (r < 82) begin
            eq = 1;
            c = "=";
         end else if (r < 88) begin
            esc = 1;
            c = 8'h1b;
         end else c = byte'($urandom_range(0, 255));
         if ($urandom_range(0, 19) == 0) esc = 1;
         if ($urandom_range(0, 14) == 0) eq = 1;
         tok(esc, eq, op, dig, c, $urandom_range(0, 12), 1'($urandom_range(0, 1)), -1);
      end
      tok(0, 0, 0, 0, 8'h00);
      repeat (2) @(negedge clk);
      chk("scoreboard drained", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
      $finish;
   end
endmodule
